// File: rtl/axioma_sleep_ctrl.sv
// Sleep/power-mode sequencer: owns SMCR, accepts SLEEP, gates clock domains,
// qualifies wake sources per mode and times oscillator start-up before resuming the CPU.
module axioma_sleep_ctrl #(
    parameter logic [5:0] ADDR_SMCR       = 6'h33,
    parameter int         STARTUP_DEEP    = 16,
    parameter int         STARTUP_STANDBY = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] io_addr,
    input  logic [7:0] io_data_in,
    output logic [7:0] io_data_out,
    input  logic       io_read,
    input  logic       io_write,
    input  logic       sleep_req,
    input  logic       wake_irq_any,
    input  logic       wake_ext_int,
    input  logic       wake_pcint,
    input  logic       wake_twi,
    input  logic       wake_wdt,
    input  logic       wake_timer2,
    input  logic       wake_adc,
    output logic       cpu_halt,
    output logic       cpu_wake,
    output logic       sleep_enable,
    output logic [2:0] sleep_mode,
    output logic       clk_cpu_en,
    output logic       clk_io_en,
    output logic       clk_adc_en,
    output logic       clk_osc_en,
    output logic       clk_async_en,
    output logic [2:0] debug_state
);

    typedef enum logic [2:0] {
        ST_ACTIVE     = 3'd0,
        ST_ENTER      = 3'd1,
        ST_SLEEP      = 3'd2,
        ST_WAKE_DELAY = 3'd3,
        ST_RESUME     = 3'd4
    } state_t;

    localparam logic [2:0] SM_IDLE        = 3'b000;
    localparam logic [2:0] SM_ADC_NR      = 3'b001;
    localparam logic [2:0] SM_POWER_DOWN  = 3'b010;
    localparam logic [2:0] SM_POWER_SAVE  = 3'b011;
    localparam logic [2:0] SM_STANDBY     = 3'b110;
    localparam logic [2:0] SM_EXT_STANDBY = 3'b111;

    localparam logic [7:0] DEEP_CNT    = STARTUP_DEEP[7:0];
    localparam logic [7:0] STANDBY_CNT = STARTUP_STANDBY[7:0];

    // {cpu_halt, cpu_wake, sleep_enable, cpu, io, adc, osc, async}
    localparam logic [7:0] OUT_ACTIVE = 8'b000_11111;
    localparam logic [7:0] OUT_RESUME = 8'b011_11111;

    function automatic logic mode_valid(input logic [2:0] sm);
        case (sm)
            SM_IDLE, SM_ADC_NR, SM_POWER_DOWN,
            SM_POWER_SAVE, SM_STANDBY, SM_EXT_STANDBY: mode_valid = 1'b1;
            default:                                   mode_valid = 1'b0;
        endcase
    endfunction

    // Domain enables {cpu, io, adc, osc, async} while the mode is sleeping
    function automatic logic [4:0] domain_en(input logic [2:0] sm);
        case (sm)
            SM_IDLE:        domain_en = 5'b01111;
            SM_ADC_NR:      domain_en = 5'b00111;
            SM_POWER_DOWN:  domain_en = 5'b00000;
            SM_POWER_SAVE:  domain_en = 5'b00001;
            SM_STANDBY:     domain_en = 5'b00010;
            SM_EXT_STANDBY: domain_en = 5'b00011;
            default:        domain_en = 5'b11111;
        endcase
    endfunction

    function automatic logic wake_cond(input logic [2:0] sm, input logic irq, input logic ext,
                                       input logic pc, input logic twi, input logic wdt,
                                       input logic t2, input logic adc);
        case (sm)
            SM_IDLE:                        wake_cond = irq;
            SM_ADC_NR:                      wake_cond = ext | pc | twi | wdt | t2 | adc;
            SM_POWER_DOWN, SM_STANDBY:      wake_cond = ext | pc | twi | wdt;
            SM_POWER_SAVE, SM_EXT_STANDBY:  wake_cond = ext | pc | twi | wdt | t2;
            default:                        wake_cond = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] out_decode(input state_t st, input logic [2:0] sm);
        case (st)
            ST_ACTIVE:          out_decode = OUT_ACTIVE;
            ST_ENTER, ST_SLEEP: out_decode = {3'b101, domain_en(sm)};
            ST_WAKE_DELAY:      out_decode = {3'b101, domain_en(sm) | 5'b00010};
            ST_RESUME:          out_decode = OUT_RESUME;
            default:            out_decode = OUT_ACTIVE;
        endcase
    endfunction

    state_t     state_r, state_nxt_s;
    logic [2:0] sm_r;
    logic       se_r;
    logic [2:0] mode_r, mode_nxt_s;
    logic [7:0] cnt_r, cnt_nxt_s;
    logic [7:0] out_r, out_nxt_s;
    logic       smcr_wr_s;
    logic       wake_s;
    logic       fast_mode_s;
    logic       unused_data_s;

    assign smcr_wr_s     = io_write && (io_addr == ADDR_SMCR);
    assign wake_s        = wake_cond(mode_r, wake_irq_any, wake_ext_int, wake_pcint,
                                     wake_twi, wake_wdt, wake_timer2, wake_adc);
    assign fast_mode_s   = (mode_r == SM_IDLE) || (mode_r == SM_ADC_NR);
    assign unused_data_s = ^io_data_in[7:4];

    // Next-state, latched mode and start-up counter
    always_comb begin
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_ACTIVE: begin
                if (sleep_req && se_r && mode_valid(sm_r)) begin
                    state_nxt_s = ST_ENTER;
                    mode_nxt_s  = sm_r;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_ENTER, ST_SLEEP: begin
                if (wake_s) begin
                    if (fast_mode_s) begin
                        state_nxt_s = ST_RESUME;
                    end else begin
                        state_nxt_s = ST_WAKE_DELAY;
                        cnt_nxt_s   = ((mode_r == SM_POWER_DOWN) || (mode_r == SM_POWER_SAVE))
                                      ? DEEP_CNT : STANDBY_CNT;
                    end
                end else begin
                    state_nxt_s = ST_SLEEP;
                end
            end
            ST_WAKE_DELAY: begin
                // Counter value is the number of WAKE_DELAY cycles still to come, this one included
                if (cnt_r <= 8'd1) begin
                    state_nxt_s = ST_RESUME;
                end else begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end
            end
            ST_RESUME: state_nxt_s = ST_ACTIVE;
            default:   state_nxt_s = ST_ACTIVE;
        endcase
        out_nxt_s = out_decode(state_nxt_s, mode_nxt_s);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_ACTIVE;
            mode_r  <= 3'd0;
            cnt_r   <= 8'd0;
            out_r   <= OUT_ACTIVE;
        end else begin
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            cnt_r   <= cnt_nxt_s;
            out_r   <= out_nxt_s;
        end
    end

    // SMCR register, writable in every state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sm_r <= 3'd0;
            se_r <= 1'b0;
        end else if (smcr_wr_s) begin
            sm_r <= io_data_in[3:1];
            se_r <= io_data_in[0];
        end else begin
            sm_r <= sm_r;
            se_r <= se_r;
        end
    end

    // SMCR read mux
    always_comb begin
        if (io_read && (io_addr == ADDR_SMCR)) begin
            io_data_out = {4'b0000, sm_r, se_r};
        end else begin
            io_data_out = 8'h00;
        end
    end

    assign cpu_halt     = out_r[7];
    assign cpu_wake     = out_r[6];
    assign sleep_enable = out_r[5];
    assign clk_cpu_en   = out_r[4];
    assign clk_io_en    = out_r[3];
    assign clk_adc_en   = out_r[2];
    assign clk_osc_en   = out_r[1];
    assign clk_async_en = out_r[0];
    assign sleep_mode   = mode_r;
    assign debug_state  = state_r;

endmodule

// File: doc/axioma_sleep_ctrl.md
Name: axioma_sleep_ctrl

Overview:
Sleep/power-mode sequencer that sits between the CPU core and the clock and reset system. It owns the ATmega328P-compatible SMCR register and accepts the CPU SLEEP instruction. It drives sleep_enable/sleep_mode into the clock system and produces per-domain clock enables. It also qualifies wake-up sources per mode and times the oscillator start-up delay before releasing the CPU.

Parameters:
ADDR_SMCR, 6'h33, I/O address of SMCR.
STARTUP_DEEP, 16, wake delay in clk cycles after POWER_DOWN/POWER_SAVE (1..255).
STARTUP_STANDBY, 6, wake delay in clk cycles after STANDBY/EXT_STANDBY (1..255).

Ports:
- clk  in  1  system clock (single clock domain).
- reset_n  in  1  asynchronous active-low reset.
- io_addr  in  6  I/O address.
- io_data_in  in  8  write data.
- io_data_out  out  8  read data.
- io_read  in  1  read strobe.
- io_write  in  1  write strobe.
- sleep_req  in  1  one-cycle pulse from CPU executing SLEEP.
- wake_irq_any  in  1  any enabled, pending interrupt (level).
- wake_ext_int  in  1  INT0/INT1 wake (level).
- wake_pcint  in  1  pin-change wake.
- wake_twi  in  1  TWI address-match wake.
- wake_wdt  in  1  watchdog interrupt wake.
- wake_timer2  in  1  asynchronous Timer2 wake.
- wake_adc  in  1  ADC conversion-complete wake.
- cpu_halt  out  1  CPU stalled.
- cpu_wake  out  1  one-cycle pulse when the CPU resumes.
- sleep_enable  out  1  to clock system; high in every state except ACTIVE.
- sleep_mode  out  3  latched SM used by the current sleep.
- clk_cpu_en  out  1  CPU clock domain enable.
- clk_io_en  out  1  I/O clock domain enable.
- clk_adc_en  out  1  ADC clock domain enable.
- clk_osc_en  out  1  main oscillator run enable.
- clk_async_en  out  1  asynchronous timer clock enable.
- debug_state  out  3  FSM state encoding.

Behaviour:
- SMCR: bits[3:1] are SM and bit0 is SE; bits[7:4] read 0. Reset value is 8'h00.
- A write to SMCR (io_write && io_addr==ADDR_SMCR) takes effect on the next clk edge and is accepted in any state.
- io_data_out is combinational: {4'b0,SM,SE} when io_read && io_addr==ADDR_SMCR, otherwise 8'h00.
- Reset (asynchronous):
  - State goes to ACTIVE and SMCR=0 and sleep_mode=0.
  - cpu_halt=0, cpu_wake=0 and sleep_enable=0.
  - All five clk_*_en outputs are 1.
  - Reset mid-sleep aborts immediately to ACTIVE.
- All outputs except io_data_out are registered or decoded from registered state (Moore).
- FSM states (debug_state encoding): ACTIVE=0, ENTER=1, SLEEP=2, WAKE_DELAY=3, RESUME=4.
- ACTIVE:
  - On sleep_req with SE=1 and SM in {000,001,010,011,110,111}, latch SM into sleep_mode and go to ENTER.
  - If SE=0 or SM is 100/101 (reserved), sleep_req is a NOP and the state stays ACTIVE.
  - If sleep_req and an SMCR write occur in the same cycle, the pre-write SMCR value is used.
  - sleep_req arriving in any state other than ACTIVE is ignored.
- ENTER (1 cycle): cpu_halt=1, domain enables per mode (table below). Evaluate the wake condition:
  - If the wake condition is true, go to RESUME for IDLE/ADC_NR, or to WAKE_DELAY for the other modes.
  - Otherwise go to SLEEP.
- SLEEP: hold. When the wake condition is true, go to RESUME for IDLE/ADC_NR, or to WAKE_DELAY for the other modes.
  - On entry to WAKE_DELAY, load the counter with STARTUP_DEEP for modes 010/011, or STARTUP_STANDBY for modes 110/111.
- WAKE_DELAY:
  - Outputs: clk_osc_en=1, cpu_halt=1, other enables as in the mode table.
  - The counter decrements each cycle; when it reaches 1, go to RESUME. Total dwell equals the loaded value in cycles.
  - Wake inputs are ignored here.
- RESUME (1 cycle): all enables=1, cpu_halt=0, cpu_wake=1, then go to ACTIVE. SMCR is not modified; SE persists.
- Domain enables (cpu, io, adc, osc, async) in ENTER/SLEEP:
  - IDLE: 0,1,1,1,1.
  - ADC_NR: 0,0,1,1,1.
  - POWER_DOWN: 0,0,0,0,0.
  - POWER_SAVE: 0,0,0,0,1.
  - STANDBY: 0,0,0,1,0.
  - EXT_STANDBY: 0,0,0,1,1.
- Wake condition by mode:
  - IDLE: wake_irq_any.
  - ADC_NR: ext_int | pcint | twi | wdt | timer2 | adc.
  - POWER_DOWN and STANDBY: ext_int | pcint | twi | wdt.
  - POWER_SAVE and EXT_STANDBY: ext_int | pcint | twi | wdt | timer2.
  - Wake inputs not listed for the active mode are ignored.

Test Plan:
1. SMCR=8'h01 (IDLE, SE). sleep_req pulse at cycle 0 -> ENTER at cycle 1 and SLEEP at cycle 2 with cpu_halt=1, clk_cpu_en=0, clk_io_en=1. wake_irq_any at cycle 5 -> RESUME at cycle 6 with cpu_wake=1, ACTIVE at cycle 7. SMCR read returns 8'h01.
2. SMCR=8'h05 (POWER_DOWN). Sleep, then assert wake_timer2 and wake_adc -> remains in SLEEP with all enables 0. Assert wake_ext_int -> WAKE_DELAY with clk_osc_en=1 for exactly 16 cycles, then RESUME and cpu_wake.
3. SMCR=8'h0D (STANDBY) -> clk_osc_en=1 while sleeping. wake_pcint -> 6-cycle WAKE_DELAY. SMCR=8'h07 (POWER_SAVE) -> clk_async_en=1 while sleeping, and wake_timer2 wakes.
4. SMCR=8'h04 (SE=0) and sleep_req -> stays ACTIVE, cpu_halt=0. SMCR=8'h09 (reserved mode 100) and sleep_req -> NOP. sleep_req with a simultaneous write of 8'h00 and old SMCR=8'h01 -> sleep is entered.
5. wake_irq_any held high before sleep_req in IDLE -> ENTER then RESUME directly, no SLEEP state, cpu_wake 2 cycles after sleep_req.
6. POWER_DOWN during WAKE_DELAY at count 8, assert reset_n=0 asynchronously -> ACTIVE immediately, SMCR=00, all enables=1, cpu_halt=0.
